// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/response memory bus between the fetch
// and load/store ports, with per-port pending slots and a bus timeout.
module mem_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        io_reqValid,
    output logic [31:0] io_addr,
    output logic        io_wen,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    input  logic        io_respValid,
    input  logic [31:0] io_rdata
);

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IFU = 2'd1;
    localparam logic [1:0] BUSY_LSU = 2'd2;

    logic [1:0]  state;
    logic        last_lsu;
    logic        ifu_pv;
    logic [31:0] ifu_pa;
    logic        lsu_pv;
    bus_req_t    lsu_slot;
    bus_req_t    owner;
    logic [15:0] cnt;

    bus_req_t ifu_live, lsu_live, ifu_cand_req, lsu_cand_req, win_req, io_pay;
    logic     ifu_cand, lsu_cand, grant_ifu, grant_lsu, issue, timeout_hit;

    assign ifu_live     = '{ifu_addr, 1'b0, 32'd0, 4'd0};
    assign lsu_live     = '{lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb};
    assign ifu_cand     = ifu_reqValid | ifu_pv;
    assign lsu_cand     = lsu_reqValid | lsu_pv;
    assign ifu_cand_req = ifu_reqValid ? ifu_live : '{ifu_pa, 1'b0, 32'd0, 4'd0};
    assign lsu_cand_req = lsu_reqValid ? lsu_live : lsu_slot;

    // On a tie the port that did not win last time gets the bus.
    assign grant_ifu = (state == IDLE) & ifu_cand & (~lsu_cand | last_lsu);
    assign grant_lsu = (state == IDLE) & lsu_cand & ~grant_ifu;
    assign issue     = grant_ifu | grant_lsu;
    assign win_req   = grant_ifu ? ifu_cand_req : lsu_cand_req;

    // Fires in the BUSY cycle that would bring the silent-cycle count to the limit.
    assign timeout_hit = (state != IDLE) && !io_respValid && (TIMEOUT_CYCLES != 16'd0)
                         && (cnt == TIMEOUT_CYCLES - 16'd1);

    assign io_reqValid = issue;
    assign io_pay      = issue ? win_req : ((state != IDLE) ? owner : '0);
    assign {io_addr, io_wen, io_wdata, io_wstrb} = io_pay;

    assign ifu_respValid = (grant_ifu && io_respValid) ||
                           (state == BUSY_IFU && (io_respValid || timeout_hit));
    assign lsu_respValid = (grant_lsu && io_respValid) ||
                           (state == BUSY_LSU && (io_respValid || timeout_hit));
    assign ifu_err       = (state == BUSY_IFU) && timeout_hit;
    assign lsu_err       = (state == BUSY_LSU) && timeout_hit;
    assign ifu_rdata     = (ifu_respValid && !ifu_err) ? io_rdata : 32'd0;
    assign lsu_rdata     = (lsu_respValid && !lsu_err) ? io_rdata : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_lsu <= 1'b1;
            ifu_pv   <= 1'b0;
            ifu_pa   <= 32'd0;
            lsu_pv   <= 1'b0;
            lsu_slot <= '0;
            owner    <= '0;
            cnt      <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && !io_respValid) begin
                        state <= grant_ifu ? BUSY_IFU : BUSY_LSU;
                        owner <= win_req;
                        cnt   <= 16'd0;
                    end
                end
                BUSY_IFU, BUSY_LSU: begin
                    if (io_respValid || timeout_hit) state <= IDLE;
                    else                             cnt   <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase

            if (issue) last_lsu <= grant_lsu;

            // Any pulse that is not issued this cycle parks in its slot.
            if (grant_ifu) begin
                ifu_pv <= 1'b0;
            end else if (ifu_reqValid) begin
                ifu_pv <= 1'b1;
                ifu_pa <= ifu_addr;
            end
            if (grant_lsu) begin
                lsu_pv <= 1'b0;
            end else if (lsu_reqValid) begin
                lsu_pv   <= 1'b1;
                lsu_slot <= lsu_live;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_reqValid = 1'b0, lsu_reqValid = 1'b0, lsu_wen = 1'b0, io_respValid = 1'b0;
    logic [31:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0, io_rdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        ifu_respValid, ifu_err, lsu_respValid, lsu_err, io_reqValid, io_wen;
    logic [31:0] ifu_rdata, lsu_rdata, io_addr, io_wdata;
    logic [3:0]  io_wstrb;

    logic        z_ifu_reqValid = 1'b0, z_io_respValid = 1'b0;
    logic [31:0] z_ifu_addr = '0, z_io_rdata = '0;
    logic        z_ifu_respValid, z_ifu_err, z_lsu_respValid, z_lsu_err, z_io_reqValid, z_io_wen;
    logic [31:0] z_ifu_rdata, z_lsu_rdata, z_io_addr, z_io_wdata;
    logic [3:0]  z_io_wstrb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.TIMEOUT_CYCLES(16'(TMO))) u_dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .io_reqValid(io_reqValid), .io_addr(io_addr), .io_wen(io_wen),
        .io_wdata(io_wdata), .io_wstrb(io_wstrb),
        .io_respValid(io_respValid), .io_rdata(io_rdata)
    );

    mem_arbiter #(.TIMEOUT_CYCLES(16'd0)) u_dz (
        .clock(clock), .reset(reset),
        .ifu_reqValid(z_ifu_reqValid), .ifu_addr(z_ifu_addr),
        .ifu_respValid(z_ifu_respValid), .ifu_rdata(z_ifu_rdata), .ifu_err(z_ifu_err),
        .lsu_reqValid(1'b0), .lsu_addr(32'd0), .lsu_wen(1'b0),
        .lsu_wdata(32'd0), .lsu_wstrb(4'd0),
        .lsu_respValid(z_lsu_respValid), .lsu_rdata(z_lsu_rdata), .lsu_err(z_lsu_err),
        .io_reqValid(z_io_reqValid), .io_addr(z_io_addr), .io_wen(z_io_wen),
        .io_wdata(z_io_wdata), .io_wstrb(z_io_wstrb),
        .io_respValid(z_io_respValid), .io_rdata(z_io_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner of the bus (-1 none, 0 ifu, 1 lsu), parked requests,
    // last winner and number of silent cycles spent waiting.
    int          m_own;
    bit          m_pend[2];
    req_t        m_slot[2];
    int          m_last;
    int          m_age;
    bit          e_ioreq;
    req_t        e_io;
    bit          e_resp[2];
    bit          e_err[2];
    logic [31:0] e_rdata[2];

    function automatic void model_reset();
        m_own = -1; m_pend[0] = 0; m_pend[1] = 0; m_last = 1; m_age = 0;
    endfunction

    task automatic cyc(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                       input bit lw, input logic [31:0] lwd, input logic [3:0] lws,
                       input bit rv, input logic [31:0] rd);
        bit   pv[2];
        req_t pr[2];
        bit   cand[2];
        req_t cr[2];
        int   w;
        @(posedge clock); #1;
        ifu_reqValid = iv; ifu_addr = ia;
        lsu_reqValid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wstrb = lws;
        io_respValid = rv; io_rdata = rd;
        pv[0] = iv; pr[0] = '{ia, 1'b0, 32'd0, 4'd0};
        pv[1] = lv; pr[1] = '{la, lw, lwd, lws};
        e_ioreq = 0; e_io = '0;
        for (int p = 0; p < 2; p++) begin e_resp[p] = 0; e_err[p] = 0; e_rdata[p] = 0; end
        w = -1;
        if (m_own < 0) begin
            for (int p = 0; p < 2; p++) begin
                cand[p] = pv[p] || m_pend[p];
                cr[p]   = pv[p] ? pr[p] : m_slot[p];
            end
            if (cand[0] && cand[1]) w = 1 - m_last;
            else if (cand[0])       w = 0;
            else if (cand[1])       w = 1;
            for (int p = 0; p < 2; p++)
                if (pv[p] && p != w) begin m_pend[p] = 1; m_slot[p] = pr[p]; end
            if (w >= 0) begin
                e_ioreq = 1; e_io = cr[w]; m_last = w; m_pend[w] = 0;
                if (rv) begin e_resp[w] = 1; e_rdata[w] = rd; end
                else begin m_own = w; m_age = 0; end
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (pv[p]) begin m_pend[p] = 1; m_slot[p] = pr[p]; end
            if (rv) begin
                e_resp[m_own] = 1; e_rdata[m_own] = rd; m_own = -1;
            end else if (TMO != 0 && m_age + 1 == TMO) begin
                e_resp[m_own] = 1; e_err[m_own] = 1; m_own = -1;
            end else begin
                m_age++;
            end
        end
        #3;
        chk("io_req", 128'(io_reqValid), 128'(e_ioreq));
        if (e_ioreq) chk("io_payload", 128'({io_addr, io_wen, io_wdata, io_wstrb}), 128'(e_io));
        chk("ifu_resp", 128'(ifu_respValid), 128'(e_resp[0]));
        chk("lsu_resp", 128'(lsu_respValid), 128'(e_resp[1]));
        if (e_resp[0]) chk("ifu_data", 128'({ifu_err, ifu_rdata}), 128'({e_err[0], e_rdata[0]}));
        if (e_resp[1]) chk("lsu_data", 128'({lsu_err, lsu_rdata}), 128'({e_err[1], e_rdata[1]}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        ifu_reqValid = 0; lsu_reqValid = 0; io_respValid = 0;
        ifu_addr = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0; io_rdata = 0;
        reset = 0;
        #1;
        chk({tag, "_io"}, 128'({io_reqValid, io_addr, io_wen, io_wdata, io_wstrb}), 128'd0);
        chk({tag, "_ifu"}, 128'({ifu_respValid, ifu_err, ifu_rdata}), 128'd0);
        chk({tag, "_lsu"}, 128'({lsu_respValid, lsu_err, lsu_rdata}), 128'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit out_i, out_l;
        int quiet;
        model_reset();
        do_reset("rst0");

        // zero-wait fetch
        cyc(1, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 32'h13);
        chk("t1_ioreq", 128'({io_reqValid, io_addr}), 128'({1'b1, 32'h8000_0000}));
        chk("t1_resp", 128'({ifu_respValid, ifu_rdata}), 128'({1'b1, 32'h13}));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_idle", 128'({io_reqValid, ifu_respValid}), 128'd0);

        // simultaneous requests after reset, latency 2
        do_reset("rst1");
        cyc(1, 32'h100, 1, 32'h200, 1, 32'hDEAD_BEEF, 4'hF, 0, 0);
        chk("t2_ifu_first", 128'({io_reqValid, io_addr, io_wen}), 128'({1'b1, 32'h100, 1'b0}));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h11);
        chk("t2_ifu_resp", 128'({ifu_respValid, io_reqValid}), 128'({1'b1, 1'b0}));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_lsu_issue", 128'({io_reqValid, io_addr, io_wen, io_wdata, io_wstrb}),
            128'({1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 4'hF}));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h22);
        cyc(1, 32'h108, 1, 32'h204, 0, 0, 0, 0, 0);
        chk("t2_next_tie", 128'({io_reqValid, io_addr}), 128'({1'b1, 32'h108}));
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h33);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h44);
        chk("t2_lsu_load", 128'({io_addr, lsu_respValid, lsu_rdata}), 128'({32'h204, 1'b1, 32'h44}));

        // fetch pulse during a load, latency 3
        cyc(0, 0, 1, 32'h300, 0, 0, 0, 0, 0);
        cyc(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        chk("t3_lsu_resp", 128'({lsu_respValid, lsu_rdata, io_reqValid}), 128'({1'b1, 32'h55, 1'b0}));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_ifu_issue", 128'({io_reqValid, io_addr}), 128'({1'b1, 32'h104}));
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h66);

        // timeout after 4 BUSY cycles, late response dropped
        cyc(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_timeout", 128'({ifu_respValid, ifu_err, ifu_rdata}), 128'({1'b1, 1'b1, 32'd0}));
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        chk("t4_late_drop", 128'({ifu_respValid, lsu_respValid, io_reqValid}), 128'd0);

        // random traffic
        out_i = 0; out_l = 0;
        for (int k = 0; k < 2000; k++) begin
            bit iv, lv, rv;
            iv = !out_i && ($urandom_range(0, 3) == 0);
            lv = !out_l && ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 99) < 35);
            cyc(iv, $urandom, lv, $urandom, 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(0, 15)), rv, $urandom);
            if (iv) out_i = 1;
            if (lv) out_l = 1;
            if (e_resp[0]) out_i = 0;
            if (e_resp[1]) out_l = 0;
        end
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1, $urandom);

        // reset mid-transaction with fetch parked
        cyc(0, 0, 1, 32'h500, 0, 0, 0, 0, 0);
        cyc(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
        do_reset("rst_mid");
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
            quiet += int'(io_reqValid) + int'(ifu_respValid) + int'(lsu_respValid);
        end
        chk("t6_quiet", 128'(quiet), 128'd0);

        // timeout disabled: response after 1000 cycles
        @(posedge clock); #1;
        z_ifu_reqValid = 1; z_ifu_addr = 32'h1000;
        #3;
        chk("tz_issue", 128'({z_io_reqValid, z_io_addr, z_io_wen, z_io_wdata, z_io_wstrb}),
            128'({1'b1, 32'h1000, 1'b0, 32'd0, 4'd0}));
        quiet = 0;
        for (int i = 0; i < 999; i++) begin
            @(posedge clock); #1;
            z_ifu_reqValid = 0;
            #3;
            quiet += int'(z_ifu_respValid) + int'(z_lsu_respValid) + int'(z_io_reqValid);
        end
        chk("tz_quiet", 128'(quiet), 128'd0);
        @(posedge clock); #1;
        z_io_respValid = 1; z_io_rdata = 32'hCAFE;
        #3;
        chk("tz_resp", 128'({z_ifu_respValid, z_ifu_err, z_ifu_rdata, z_lsu_respValid, z_lsu_err, z_lsu_rdata}),
            128'({1'b1, 1'b0, 32'hCAFE, 1'b0, 1'b0, 32'd0}));
        @(posedge clock); #1;
        z_io_respValid = 0;
        #3;
        chk("tz_after", 128'({z_ifu_respValid, z_io_reqValid}), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
